// File: rtl/mmio_cntr.sv
// Purpose : MMIO controller; serves CLINT mtime/mtimecmp and a UART locally, forwards other requests to memory.
// Latency : MMIO response one cycle after acceptance; memory requests pass through combinationally, response mirrored.
// Backpr. : one request outstanding; ready drops during a response and stalls UART DATA writes while TX is busy.
// Ports   : clk/reset (sync, active-high); uart_rx/uart_tx serial 8N1;
//           dreq_in_* / dresp_in_* upstream request/response; memreq_in_* / memresp_in_* downstream;
//           mti_pending (mtime >= mtimecmp), uart_rx_pending (unread rx byte held).
module mmio_cntr #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic        dreq_in_valid,
    output logic        dreq_in_ready,
    input  logic [31:0] dreq_in_addr,
    input  logic        dreq_in_wen,
    input  logic [31:0] dreq_in_wdata,
    input  logic [3:0]  dreq_in_wmask,
    output logic        dresp_in_valid,
    output logic        dresp_in_error,
    output logic [31:0] dresp_in_rdata,
    output logic        memreq_in_valid,
    input  logic        memreq_in_ready,
    output logic [31:0] memreq_in_addr,
    output logic        memreq_in_wen,
    output logic [31:0] memreq_in_wdata,
    output logic [3:0]  memreq_in_wmask,
    input  logic        memresp_in_valid,
    input  logic        memresp_in_error,
    input  logic [31:0] memresp_in_rdata,
    output logic        mti_pending,
    output logic        uart_rx_pending
);

    localparam int          BIT_CYC   = CLK_FREQ / BAUD;
    localparam logic [31:0] BIT_LAST  = 32'(BIT_CYC - 1);
    localparam logic [31:0] HALF_LAST = 32'(BIT_CYC / 2 - 1);

    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;
    localparam logic [31:0] A_DATA   = 32'h1000_0000;
    localparam logic [31:0] A_STAT   = 32'h1000_0004;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MRESP = 2'd1;
    localparam logic [1:0] S_MWAIT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        tx_busy_q, tx_busy_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;

    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        rx_busy_q, rx_busy_d;
    logic [31:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_vld_q, rx_vld_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode (byte offset ignored)
    logic in_clint, in_uart, is_mmio;
    logic hit_cmp_lo, hit_cmp_hi, hit_mt_lo, hit_mt_hi, hit_data, hit_stat;
    logic tx_stall, mmio_acc, mem_acc, wr_acc, data_rd;
    logic [31:0] rd_val;

    assign in_clint   = (dreq_in_addr[31:16] == 16'h0200);
    assign in_uart    = (dreq_in_addr[31:12] == 20'h10000);
    assign is_mmio    = in_clint | in_uart;
    assign hit_cmp_lo = (dreq_in_addr[31:2] == A_CMP_LO[31:2]);
    assign hit_cmp_hi = (dreq_in_addr[31:2] == A_CMP_HI[31:2]);
    assign hit_mt_lo  = (dreq_in_addr[31:2] == A_MT_LO[31:2]);
    assign hit_mt_hi  = (dreq_in_addr[31:2] == A_MT_HI[31:2]);
    assign hit_data   = (dreq_in_addr[31:2] == A_DATA[31:2]);
    assign hit_stat   = (dreq_in_addr[31:2] == A_STAT[31:2]);

    // A DATA write cannot be taken while the transmitter still owns the shift register
    assign tx_stall = (state_q == S_IDLE) && dreq_in_valid && dreq_in_wen && hit_data && tx_busy_q;
    assign mmio_acc = (state_q == S_IDLE) && dreq_in_valid && is_mmio && !tx_stall;
    assign mem_acc  = (state_q == S_IDLE) && dreq_in_valid && !is_mmio && memreq_in_ready;
    assign wr_acc   = mmio_acc && dreq_in_wen;
    assign data_rd  = mmio_acc && !dreq_in_wen && hit_data;

    always_comb begin
        if (state_q != S_IDLE)                dreq_in_ready = 1'b0;
        else if (dreq_in_valid && !is_mmio)   dreq_in_ready = memreq_in_ready;
        else                                  dreq_in_ready = !tx_stall;
    end

    assign memreq_in_valid = (state_q == S_IDLE) && dreq_in_valid && !is_mmio;
    assign memreq_in_addr  = dreq_in_addr;
    assign memreq_in_wen   = dreq_in_wen;
    assign memreq_in_wdata = dreq_in_wdata;
    assign memreq_in_wmask = dreq_in_wmask;

    assign dresp_in_valid = (state_q == S_MRESP) || ((state_q == S_MWAIT) && memresp_in_valid);
    assign dresp_in_error = (state_q == S_MWAIT) && memresp_in_error;
    assign dresp_in_rdata = (state_q == S_MWAIT) ? memresp_in_rdata : rdata_q;

    assign mti_pending     = (mtime_q >= mtimecmp_q);
    assign uart_rx_pending = rx_vld_q;
    assign uart_tx         = tx_busy_q ? tx_shift_q[0] : 1'b1;

    // Read mux sees pre-increment mtime because it uses the current register value
    always_comb begin
        rd_val = 32'h0;
        if (hit_cmp_lo)      rd_val = mtimecmp_q[31:0];
        else if (hit_cmp_hi) rd_val = mtimecmp_q[63:32];
        else if (hit_mt_lo)  rd_val = mtime_q[31:0];
        else if (hit_mt_hi)  rd_val = mtime_q[63:32];
        else if (hit_data)   rd_val = {24'h0, rx_byte_q};
        else if (hit_stat)   rd_val = {30'h0, tx_busy_q, rx_vld_q};
    end

    always_comb begin
        state_d    = state_q;
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        rdata_d    = rdata_q;
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_vld_d   = rx_vld_q;

        // Request/response sequencing
        case (state_q)
            S_IDLE: begin
                if (mmio_acc)     state_d = S_MRESP;
                else if (mem_acc) state_d = S_MWAIT;
            end
            S_MRESP: state_d = S_IDLE;
            S_MWAIT: if (memresp_in_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (mmio_acc) rdata_d = rd_val;

        // Register writes; an mtime write replaces this cycle's increment
        if (wr_acc && hit_cmp_lo)
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], dreq_in_wdata, dreq_in_wmask);
        if (wr_acc && hit_cmp_hi)
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], dreq_in_wdata, dreq_in_wmask);
        if (wr_acc && hit_mt_lo)
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], dreq_in_wdata, dreq_in_wmask)};
        if (wr_acc && hit_mt_hi)
            mtime_d = {merge_bytes(mtime_q[63:32], dreq_in_wdata, dreq_in_wmask), mtime_q[31:0]};

        // Transmitter: shift register holds {stop, data, start}, LSB on the line
        if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = 32'h0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
                else                  tx_bit_d  = tx_bit_q + 4'd1;
            end else begin
                tx_cnt_d = tx_cnt_q + 32'd1;
            end
        end
        if (wr_acc && hit_data) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, dreq_in_wdata[7:0], 1'b0};
            tx_cnt_d   = 32'h0;
            tx_bit_d   = 4'd0;
        end

        // Reading DATA consumes the byte; a byte completing this same cycle wins below
        if (data_rd) rx_vld_d = 1'b0;

        // Receiver: bit 0 = start (sampled after half a bit), 1..8 = data, 9 = stop
        if (!rx_busy_q) begin
            if (rx_s3_q && !rx_s2_q) begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = 32'h0;
                rx_bit_d  = 4'd0;
            end
        end else if (rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST)) begin
            rx_cnt_d = 32'h0;
            if (rx_bit_q == 4'd0) begin
                if (rx_s2_q) rx_busy_d = 1'b0;
                else         rx_bit_d  = 4'd1;
            end else if (rx_bit_q == 4'd9) begin
                rx_busy_d = 1'b0;
                if (rx_s2_q) begin
                    rx_byte_d = rx_sh_q;
                    rx_vld_d  = 1'b1;
                end
            end else begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 4'd1;
            end
        end else begin
            rx_cnt_d = rx_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mtime_q    <= 64'h0;
            mtimecmp_q <= '1;
            rdata_q    <= 32'h0;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= 32'h0;
            tx_bit_q   <= 4'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= 32'h0;
            rx_bit_q   <= 4'd0;
            rx_sh_q    <= 8'h0;
            rx_byte_q  <= 8'h0;
            rx_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_vld_q   <= rx_vld_d;
        end
    end

endmodule

// File: tb/tb_mmio_cntr.sv
// Purpose : directed bench for mmio_cntr with a timestamp-based reference model of timer and UART TX.
// Latency : model assumes MMIO response one cycle after acceptance; TX frame starts the cycle after the write.
// Backpr. : drives requests and waits (bounded) on dreq_in_ready.
module tb_mmio_cntr;
    localparam int CF  = 1600;
    localparam int BD  = 100;
    localparam int BIT = CF / BD;

    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;
    localparam logic [31:0] A_DATA   = 32'h1000_0000;
    localparam logic [31:0] A_STAT   = 32'h1000_0004;

    logic        clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, uart_tx;
    logic        dreq_in_valid = 1'b0, dreq_in_ready, dreq_in_wen = 1'b0;
    logic [31:0] dreq_in_addr = '0, dreq_in_wdata = '0;
    logic [3:0]  dreq_in_wmask = '0;
    logic        dresp_in_valid, dresp_in_error;
    logic [31:0] dresp_in_rdata;
    logic        memreq_in_valid, memreq_in_ready = 1'b0, memreq_in_wen;
    logic [31:0] memreq_in_addr, memreq_in_wdata;
    logic [3:0]  memreq_in_wmask;
    logic        memresp_in_valid = 1'b0, memresp_in_error = 1'b0;
    logic [31:0] memresp_in_rdata = '0;
    logic        mti_pending, uart_rx_pending;

    mmio_cntr #(.CLK_FREQ(CF), .BAUD(BD)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .dreq_in_valid(dreq_in_valid), .dreq_in_ready(dreq_in_ready), .dreq_in_addr(dreq_in_addr),
        .dreq_in_wen(dreq_in_wen), .dreq_in_wdata(dreq_in_wdata), .dreq_in_wmask(dreq_in_wmask),
        .dresp_in_valid(dresp_in_valid), .dresp_in_error(dresp_in_error), .dresp_in_rdata(dresp_in_rdata),
        .memreq_in_valid(memreq_in_valid), .memreq_in_ready(memreq_in_ready), .memreq_in_addr(memreq_in_addr),
        .memreq_in_wen(memreq_in_wen), .memreq_in_wdata(memreq_in_wdata), .memreq_in_wmask(memreq_in_wmask),
        .memresp_in_valid(memresp_in_valid), .memresp_in_error(memresp_in_error),
        .memresp_in_rdata(memresp_in_rdata),
        .mti_pending(mti_pending), .uart_rx_pending(uart_rx_pending)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: after the k-th live edge this reads k
    int cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Reference model: mtime = base + elapsed cycles; TX frame described by its start cycle and byte
    logic [63:0] mt_base, m_cmp;
    int          mt_cyc, tx_c;
    logic [7:0]  tx_b, m_rx_byte;
    logic        m_rx_vld;
    int          n_cmp, n_fail;
    logic [31:0] rd;
    int          c0, nw;
    int          exp_bits [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    function automatic logic [63:0] mt_at(input int k);
        return mt_base + 64'(k - mt_cyc);
    endfunction

    function automatic logic tx_busy_at(input int k);
        return (k >= tx_c) && (k < tx_c + 10 * BIT);
    endfunction

    function automatic logic tx_exp(input int k);
        logic [9:0] f;
        f = {1'b1, tx_b, 1'b0};
        if (tx_busy_at(k)) return f[(k - tx_c) / BIT];
        return 1'b1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] w, input int pre);
        logic [63:0] t;
        t = mt_at(pre);
        case (w)
            A_CMP_LO: return m_cmp[31:0];
            A_CMP_HI: return m_cmp[63:32];
            A_MT_LO:  return t[31:0];
            A_MT_HI:  return t[63:32];
            A_DATA:   return {24'h0, m_rx_byte};
            A_STAT:   return {30'h0, tx_busy_at(pre), m_rx_vld};
            default:  return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Advance to the next falling edge and check the always-meaningful outputs against the model
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            chk("mti_pending", {63'h0, mti_pending}, {63'h0, mt_at(cyc) >= m_cmp});
            chk("uart_tx", {63'h0, uart_tx}, {63'h0, tx_exp(cyc)});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dreq_in_valid = 1'b0; memreq_in_ready = 1'b0; memresp_in_valid = 1'b0; uart_rx = 1'b1;
        tick(); tick(); tick();
        mt_base = 64'h0; mt_cyc = 0; m_cmp = '1; tx_c = -100000; tx_b = 8'h0;
        m_rx_vld = 1'b0; m_rx_byte = 8'h0;
        reset = 1'b0;
    endtask

    task automatic mmio(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] wm, output logic [31:0] rdo);
        int pre, n;
        logic [31:0] w, e_rd;
        logic [63:0] old;
        dreq_in_valid = 1'b1; dreq_in_addr = a; dreq_in_wen = we;
        dreq_in_wdata = wd; dreq_in_wmask = wm;
        #1;
        n = 0;
        while (!dreq_in_ready && n < 3000) begin
            tick(); #1; n++;
        end
        chk("req_accept", {63'h0, dreq_in_ready}, 64'h1);
        rdo = 32'h0;
        if (!dreq_in_ready) begin
            dreq_in_valid = 1'b0;
            return;
        end
        pre  = cyc;
        w    = {a[31:2], 2'b00};
        e_rd = exp_read(w, pre);
        if (we) begin
            old = mt_at(pre);
            case (w)
                A_CMP_LO: m_cmp[31:0]  = merge(m_cmp[31:0], wd, wm);
                A_CMP_HI: m_cmp[63:32] = merge(m_cmp[63:32], wd, wm);
                A_MT_LO: begin mt_base = {old[63:32], merge(old[31:0], wd, wm)}; mt_cyc = pre + 1; end
                A_MT_HI: begin mt_base = {merge(old[63:32], wd, wm), old[31:0]}; mt_cyc = pre + 1; end
                A_DATA:  begin tx_c = pre + 1; tx_b = wd[7:0]; end
                default: ;
            endcase
        end else if (w == A_DATA) begin
            m_rx_vld = 1'b0;
        end
        tick();
        dreq_in_valid = 1'b0;
        #1;
        chk("resp_valid", {63'h0, dresp_in_valid}, 64'h1);
        chk("resp_error", {63'h0, dresp_in_error}, 64'h0);
        if (!we) chk("resp_rdata", {32'h0, dresp_in_rdata}, {32'h0, e_rd});
        rdo = dresp_in_rdata;
        tick(); #1;
        chk("resp_once", {63'h0, dresp_in_valid}, 64'h0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (BIT) tick();
        end
        uart_rx = 1'b1;
        if (stop) begin
            m_rx_vld = 1'b1; m_rx_byte = b;
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        mt_base = 64'h0; mt_cyc = 0; m_cmp = '1; tx_c = -100000; tx_b = 8'h0;
        m_rx_vld = 1'b0; m_rx_byte = 8'h0;
        do_reset();
        #1;
        chk("rst_ready", {63'h0, dreq_in_ready}, 64'h1);
        chk("rst_dresp", {63'h0, dresp_in_valid}, 64'h0);
        chk("rst_memreq", {63'h0, memreq_in_valid}, 64'h0);
        chk("rst_tx", {63'h0, uart_tx}, 64'h1);
        chk("rst_mti", {63'h0, mti_pending}, 64'h0);
        chk("rst_rxp", {63'h0, uart_rx_pending}, 64'h0);

        // Timer
        repeat (10) tick();
        mmio(A_MT_LO, 1'b0, 0, 4'h0, rd);
        chk("mtime_after_10", {32'h0, rd}, 64'd10);
        mmio(A_MT_HI, 1'b0, 0, 4'h0, rd);
        mmio(A_CMP_HI, 1'b1, 32'h0, 4'hF, rd);
        mmio(A_CMP_LO, 1'b1, 32'd100, 4'hF, rd);
        mmio(A_CMP_LO, 1'b0, 0, 4'h0, rd);
        chk("cmp_lo_rd", {32'h0, rd}, 64'd100);
        nw = 0;
        while (!mti_pending && nw < 500) begin tick(); nw++; end
        chk("mti_rise_cycle", 64'(cyc), 64'd100);
        mmio(A_CMP_LO, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        mmio(A_CMP_HI, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        chk("mti_clear", {63'h0, mti_pending}, 64'h0);
        mmio(A_CMP_LO, 1'b1, 32'h0000_00AB, 4'b0001, rd);
        mmio(A_CMP_LO, 1'b0, 0, 4'h0, rd);
        chk("cmp_wmask", {32'h0, rd}, 64'hFFFF_FFAB);
        mmio(A_MT_LO, 1'b1, 32'd5000, 4'hF, rd);
        repeat (3) tick();
        mmio(A_MT_LO, 1'b0, 0, 4'h0, rd);
        chk("mtime_write", {32'h0, rd}, 64'd5004);
        mmio(32'h0200_0010, 1'b1, 32'h1234_5678, 4'hF, rd);
        mmio(32'h0200_0010, 1'b0, 0, 4'h0, rd);
        chk("clint_hole", {32'h0, rd}, 64'h0);
        mmio(32'h1000_0008, 1'b0, 0, 4'h0, rd);
        chk("uart_hole", {32'h0, rd}, 64'h0);

        // UART transmit
        mmio(A_DATA, 1'b1, 32'h41, 4'hF, rd);
        c0 = tx_c;
        mmio(A_STAT, 1'b0, 0, 4'h0, rd);
        chk("stat_tx_busy", {32'h0, rd}, 64'h2);
        for (int i = 0; i < 10; i++) begin
            while (cyc < c0 + i * BIT + BIT / 2) tick();
            chk($sformatf("tx_bit%0d", i), {63'h0, uart_tx}, 64'(exp_bits[i]));
        end
        dreq_in_valid = 1'b1; dreq_in_addr = A_DATA; dreq_in_wen = 1'b1;
        dreq_in_wdata = 32'h55; dreq_in_wmask = 4'hF;
        #1;
        chk("tx_stall", {63'h0, dreq_in_ready}, 64'h0);
        mmio(A_DATA, 1'b1, 32'h55, 4'hF, rd);
        chk("tx_stall_release", 64'(tx_c), 64'(c0 + 10 * BIT + 1));
        repeat (10 * BIT + 2) tick();

        // UART receive
        chk("rxp_idle", {63'h0, uart_rx_pending}, 64'h0);
        send_rx(8'h5A, 1'b1);
        chk("rxp_set", {63'h0, uart_rx_pending}, 64'h1);
        mmio(A_STAT, 1'b0, 0, 4'h0, rd);
        chk("stat_rx", {32'h0, rd}, 64'h1);
        mmio(A_DATA, 1'b0, 0, 4'h0, rd);
        chk("rx_data", {32'h0, rd}, 64'h5A);
        chk("rxp_cleared", {63'h0, uart_rx_pending}, 64'h0);
        send_rx(8'h33, 1'b0);
        repeat (BIT) tick();
        chk("rx_framing", {63'h0, uart_rx_pending}, 64'h0);
        uart_rx = 1'b0; tick(); tick(); uart_rx = 1'b1;
        repeat (12 * BIT) tick();
        chk("rx_glitch", {63'h0, uart_rx_pending}, 64'h0);
        send_rx(8'hC3, 1'b1);
        send_rx(8'h96, 1'b1);
        mmio(A_DATA, 1'b0, 0, 4'h0, rd);
        chk("rx_overwrite", {32'h0, rd}, 64'h96);

        // Memory pass-through
        tick();
        dreq_in_valid = 1'b1; dreq_in_addr = 32'h8000_0000; dreq_in_wen = 1'b0;
        dreq_in_wdata = 32'h1122_3344; dreq_in_wmask = 4'hF; memreq_in_ready = 1'b0;
        #1;
        chk("mem_valid", {63'h0, memreq_in_valid}, 64'h1);
        chk("mem_addr", {32'h0, memreq_in_addr}, 64'h8000_0000);
        chk("mem_wen", {63'h0, memreq_in_wen}, 64'h0);
        chk("mem_wdata", {32'h0, memreq_in_wdata}, 64'h1122_3344);
        chk("mem_wmask", {60'h0, memreq_in_wmask}, 64'hF);
        chk("mem_ready_low", {63'h0, dreq_in_ready}, 64'h0);
        tick(); memreq_in_ready = 1'b1; #1;
        chk("mem_ready_follow", {63'h0, dreq_in_ready}, 64'h1);
        tick(); dreq_in_valid = 1'b0; memreq_in_ready = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            chk("mwait_ready", {63'h0, dreq_in_ready}, 64'h0);
            chk("mwait_memreq", {63'h0, memreq_in_valid}, 64'h0);
            chk("mwait_dresp", {63'h0, dresp_in_valid}, 64'h0);
            tick(); #1;
        end
        memresp_in_valid = 1'b1; memresp_in_rdata = 32'hDEAD_BEEF; memresp_in_error = 1'b0; #1;
        chk("mem_resp_valid", {63'h0, dresp_in_valid}, 64'h1);
        chk("mem_resp_rdata", {32'h0, dresp_in_rdata}, 64'hDEAD_BEEF);
        chk("mem_resp_error", {63'h0, dresp_in_error}, 64'h0);
        tick(); memresp_in_valid = 1'b0; #1;
        chk("mem_done_valid", {63'h0, dresp_in_valid}, 64'h0);
        chk("mem_done_ready", {63'h0, dreq_in_ready}, 64'h1);

        // Reset during TX
        mmio(A_DATA, 1'b1, 32'h77, 4'hF, rd);
        repeat (30) tick();
        do_reset();
        #1;
        chk("rst_tx_line", {63'h0, uart_tx}, 64'h1);
        chk("rst_tx_ready", {63'h0, dreq_in_ready}, 64'h1);
        chk("rst_tx_dresp", {63'h0, dresp_in_valid}, 64'h0);
        mmio(A_STAT, 1'b0, 0, 4'h0, rd);
        chk("rst_tx_stat", {32'h0, rd}, 64'h0);

        // Reset during MWAIT
        dreq_in_valid = 1'b1; dreq_in_addr = 32'h8000_0010; dreq_in_wen = 1'b0; memreq_in_ready = 1'b1;
        tick(); dreq_in_valid = 1'b0; memreq_in_ready = 1'b0; #1;
        chk("mwait2_ready", {63'h0, dreq_in_ready}, 64'h0);
        tick();
        do_reset();
        #1;
        chk("rst_mw_dresp", {63'h0, dresp_in_valid}, 64'h0);
        chk("rst_mw_ready", {63'h0, dreq_in_ready}, 64'h1);
        chk("rst_mw_memreq", {63'h0, memreq_in_valid}, 64'h0);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_cntr.md
Name: mmio_cntr

Overview:
- Memory-mapped I/O controller on the data path between the data-side page-table walker (upstream) and the misaligned-access controller/D-cache (downstream).
- Decodes CLINT timer (mtime/mtimecmp) and UART addresses and serves them locally; forwards all other requests unchanged downstream.
- Drives the machine-timer interrupt line (mti_pending) and the UART-receive interrupt line (uart_rx_pending).

Parameters:
- CLK_FREQ, 27000000: clock frequency in Hz.
- BAUD, 115200: UART baud rate; bit period = CLK_FREQ/BAUD cycles, integer-truncated.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- uart_rx  in  1  serial input, 8N1, idle high.
- uart_tx  out  1  serial output, 8N1, idle high.
- dreq_in  CacheReq  upstream request: valid(in), ready(out), addr(in,32), wen(in,1), wdata(in,32), wmask(in,4 byte enables).
- dresp_in  CacheResp  upstream response (out): valid, error, rdata(32).
- memreq_in  CacheReq  downstream request: valid(out), ready(in), addr/wen/wdata/wmask(out).
- memresp_in  CacheResp  downstream response (in): valid, error, rdata.
- mti_pending  out  1  high when mtime >= mtimecmp (unsigned 64-bit compare).
- uart_rx_pending  out  1  high while an unread received byte is held.

Behaviour:
- Address map (word-aligned, addr[1:0] ignored):
  - mtimecmp lo 0x02004000, hi 0x02004004.
  - mtime lo 0x0200BFF8, hi 0x0200BFFC.
  - UART DATA 0x10000000: write sends wdata[7:0]; read returns {24'b0, rx byte} and clears the rx-valid flag.
  - UART STATUS 0x10000004: read-only; bit0 = rx valid, bit1 = tx busy, other bits 0.
- Any other address inside 0x02000000–0x0200FFFF or 0x10000000–0x10000FFF: reads return 0, writes are ignored, error = 0.
- Addresses outside those two ranges are "memory" and are passed downstream.
- Register writes honour wmask byte enables (mtime, mtimecmp).
- mtime: 64-bit, +1 every cycle; a write in a cycle takes priority over the increment.
- Reset values:
  - mtime = 0, mtimecmp = all-ones, so mti_pending = 0.
  - dreq_in.ready = 1, dresp_in.valid = 0, memreq_in.valid = 0.
  - uart_tx = 1, rx flag = 0, state = IDLE.
- States:
  - IDLE: dreq_in.ready = 1 except while a UART DATA write is presented with tx busy (ready = 0, request stalls).
    - MMIO request accepted (valid & ready): perform the access, go to MRESP.
    - Memory request: combinationally drive memreq_in from dreq_in; dreq_in.ready = memreq_in.ready. On acceptance go to MWAIT.
  - MRESP: dresp_in.valid = 1 for exactly one cycle with rdata and error = 0; dreq_in.ready = 0; next state IDLE.
    - MMIO latency: response in the cycle after acceptance.
    - Read data is sampled at acceptance; mtime reads return the pre-increment value.
  - MWAIT: dreq_in.ready = 0, memreq_in.valid = 0.
    - dresp_in mirrors memresp_in (valid/error/rdata).
    - On memresp_in.valid return to IDLE; a new request may be accepted the following cycle.
- At most one outstanding request at any time.
- UART TX: write latches the byte, sets tx busy, and sends start(0), 8 data bits LSB-first, stop(1), each held one bit period. Busy clears after the stop bit.
- UART RX:
  - Two-flop synchronizer; falling edge starts reception.
  - Sample at mid-bit; a start bit that is not 0 at mid-bit is aborted.
  - On a valid stop bit, store the byte and set rx valid. A framing error (stop bit = 0) discards the byte.
  - A new byte overwrites an unread one.
  - If a DATA read and byte completion coincide, the new byte wins and rx valid stays 1.
- uart_rx_pending = rx valid, registered.
- mti_pending is combinational from the registers.
- reset mid-transfer aborts TX/RX, drops any pending response, returns to IDLE, and clears all state.

Test Plan:
- Reset, then idle 10 cycles -> mti_pending = 0, uart_tx = 1, read 0x0200BFF8 returns ≈ cycle count since reset; MMIO response one cycle after acceptance.
- Write mtimecmp hi = 0, lo = 100 -> mti_pending rises exactly when mtime reaches 100; writing lo = 0xFFFFFFFF, hi = 0xFFFFFFFF clears it.
- Write 0x41 to 0x10000000 -> uart_tx shows 0,1,0,0,0,0,0,1,0,1 at BAUD; STATUS bit1 = 1 during the frame; a second write stalls (ready = 0) until done.
- Drive 0x5A serially on uart_rx -> uart_rx_pending = 1, STATUS = 0x1, DATA read = 0x5A, then uart_rx_pending = 0.
- Read 0x80000000 with memory returning 0xDEADBEEF after 3 cycles -> memreq_in fields equal the request; dresp_in.valid/rdata mirror it; ready low until the response.
- Assert reset during TX and during MWAIT -> uart_tx = 1, no dresp_in.valid, ready = 1 next cycle.
